axis_ring_addr_gen: RTL and testbench

- Upstream feeder for the AXI-Stream-to-AXI-MM write bridge. It places incoming stream beats into a host memory ring buffer, one KEEP_WIDTH-byte slot per beat.
- Per beat, it computes the slot's write address (ring base plus write offset, with wrap-around) and presents it alongside the registered beat.
- Provides back-pressure when the ring is full, tracked against a consumer read pointer.
- Drops whole frames that arrive while the ring is disabled.

---
 rtl/axis_ring_addr_gen.sv | 151 +++++++++++++++
 tb/tb_axis_ring_addr_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ring_addr_gen.sv
// Stream-to-ring address generator: registers each beat with its slot address.
// Ports: s_axis in, m_axis+m_addr out, cfg_* ring setup, counters. Option AXIS_RING_STATS_EN.
module axis_ring_addr_gen #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 34,
  parameter int OFFS_WIDTH = 24,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cfg_ring_base,
  input  logic [OFFS_WIDTH-1:0] cfg_ring_size,
  input  logic                  cfg_enable,
  input  logic [OFFS_WIDTH-1:0] cfg_rd_offs,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_addr_valid,
  output logic [OFFS_WIDTH-1:0] wr_offs,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [OFFS_WIDTH:0] SLOT =
    (OFFS_WIDTH+1)'(KEEP_WIDTH);

  state_t state, state_nxt;

  logic [OFFS_WIDTH-1:0] cur_offs;
  logic [OFFS_WIDTH-1:0] offs_nxt;
  logic [OFFS_WIDTH:0]   size_x;
  logic [OFFS_WIDTH:0]   diff;
  logic [OFFS_WIDTH:0]   occ;
  logic [OFFS_WIDTH:0]   inc;
  logic                  full;
  logic                  load_ok;
  logic                  in_hs;
  logic                  pass_hs;
  logic                  drop_hs;

  assign size_x = {1'b0, cfg_ring_size};
  assign diff   = {1'b0, cur_offs} - {1'b0, cfg_rd_offs};
  // Read pointer ahead of write pointer means we wrapped.
  assign occ    = (cur_offs < cfg_rd_offs) ? diff + size_x : diff;
  // One slot stays empty so full and empty differ.
  assign full   = (occ + SLOT) >= size_x;
  assign inc    = {1'b0, cur_offs} + SLOT;
  assign offs_nxt = (inc == size_x) ? '0 : inc[OFFS_WIDTH-1:0];

  assign load_ok = !m_axis_tvalid || m_axis_tready;
  assign in_hs   = s_axis_tvalid && s_axis_tready;
  assign pass_hs = in_hs && (state == PASS);
  assign drop_hs = in_hs && (state == DROP);

  assign m_addr_valid = m_axis_tvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (s_axis_tvalid)
          state_nxt = cfg_enable ? PASS : DROP;
      end
      PASS: if (pass_hs && s_axis_tlast) state_nxt = IDLE;
      DROP: if (drop_hs && s_axis_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state)
      PASS:    s_axis_tready = !full && load_ok;
      DROP:    s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_addr        <= '0;
    end else begin
      if (load_ok) m_axis_tvalid <= pass_hs;
      if (pass_hs) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= s_axis_tkeep;
        m_axis_tlast <= s_axis_tlast;
        m_addr <= cfg_ring_base + ADDR_WIDTH'(cur_offs);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_offs    <= '0;
      wr_offs     <= '0;
      frame_count <= '0;
    end else if (pass_hs) begin
      cur_offs <= offs_nxt;
      if (s_axis_tlast) begin
        wr_offs <= offs_nxt;
        if (frame_count != '1)
          frame_count <= frame_count + CNT_WIDTH'(1);
      end
    end
  end

`ifdef AXIS_RING_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count  <= '0;
      stall_count <= '0;
    end else begin
      if (drop_hs && s_axis_tlast && drop_count != '1)
        drop_count <= drop_count + CNT_WIDTH'(1);
      if (state == PASS && s_axis_tvalid && full &&
          stall_count != '1)
        stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end
`else
  assign drop_count  = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_axis_ring_addr_gen.sv
// Scoreboard bench for axis_ring_addr_gen.
// Expected beats are queued on input handshake and popped on output handshake.
module tb_axis_ring_addr_gen;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int AW = 34;
  localparam int OW = 24;
  localparam int CW = 32;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] cfg_ring_base;
  logic [OW-1:0] cfg_ring_size;
  logic          cfg_enable;
  logic [OW-1:0] cfg_rd_offs;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [AW-1:0] m_addr;
  logic          m_addr_valid;
  logic [OW-1:0] wr_offs;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] stall_count;

  axis_ring_addr_gen dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_ring_base(cfg_ring_base),
    .cfg_ring_size(cfg_ring_size),
    .cfg_enable(cfg_enable),
    .cfg_rd_offs(cfg_rd_offs),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_addr(m_addr),
    .m_addr_valid(m_addr_valid),
    .wr_offs(wr_offs),
    .frame_count(frame_count),
    .drop_count(drop_count),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int checks = 0;
  int failures = 0;
  int beats_acc = 0;
  logic [OW-1:0] mdl_offs;
  logic [OW-1:0] mdl_size;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", m_axis_tvalid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("m_addr", m_addr, mon_e.addr);
        chk("m_tdata", m_axis_tdata, mon_e.data);
        chk("m_tkeep", m_axis_tkeep, mon_e.keep);
        chk("m_tlast", m_axis_tlast, mon_e.last);
        chk("addr_valid", m_addr_valid, 1'b1);
      end
    end
  end

  task automatic send_frame(input int n, input bit pass,
                            input int stop_after);
    logic [DW-1:0] d;
    int w;
    int acc;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < DW / 32; k++)
        d[k*32 +: 32] = $urandom();
      s_axis_tdata  = d;
      s_axis_tkeep  = (i == n - 1) ? 64'h0000_0000_0000_0fff : '1;
      s_axis_tlast  = (i == n - 1);
      s_axis_tvalid = 1'b1;
      w = 0;
      @(negedge clk);
      if (!pass && i > 0) chk("drop_tready", s_axis_tready, 1'b1);
      while (!s_axis_tready && w < 200) begin
        w++;
        @(negedge clk);
      end
      if (!s_axis_tready) begin
        chk("in_timeout", s_axis_tready, 1'b1);
        s_axis_tvalid = 1'b0;
        return;
      end
      if (pass) begin
        sb.push_back('{addr: cfg_ring_base + AW'(mdl_offs),
                       data: s_axis_tdata,
                       keep: s_axis_tkeep,
                       last: s_axis_tlast});
        mdl_offs = mdl_offs + OW'(KW);
        if (mdl_offs == mdl_size) mdl_offs = '0;
      end
      acc++;
      beats_acc++;
      @(posedge clk);
      #1;
      if (stop_after > 0 && acc == stop_after) begin
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    mdl_offs = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int w;
  logic [CW-1:0] st0;

  initial begin
    rst_n = 1'b0;
    cfg_ring_base = '0;
    cfg_ring_size = 24'h400;
    cfg_enable = 1'b1;
    cfg_rd_offs = '0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    mdl_offs = '0;
    mdl_size = 24'h400;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_mvalid", m_axis_tvalid, 1'b0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_wr_offs", wr_offs, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_drops", drop_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame with one output back-pressure cycle.
    cfg_ring_base = 34'h1_0000_0000;
    fork
      send_frame(3, 1'b1, 0);
      begin
        repeat (3) @(posedge clk);
        #1 m_axis_tready = 1'b0;
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
      end
    join
    wait_drain();
    chk("t1_wr_offs", wr_offs, 24'hc0);
    chk("t1_frames", frame_count, 1);

    // Wrap at ring end.
    cfg_ring_size = 24'h100;
    mdl_size = 24'h100;
    cfg_rd_offs = 24'hc0;
    send_frame(2, 1'b1, 0);
    wait_drain();
    chk("t2_wr_offs", wr_offs, 24'h40);
    chk("t2_frames", frame_count, 2);

    // Full ring stalls the fourth beat.
    do_reset();
    cfg_rd_offs = '0;
    beats_acc = 0;
    fork
      send_frame(4, 1'b1, 0);
      begin
        repeat (10) @(posedge clk);
        #1;
        st0 = stall_count;
        chk("t3_tready_full", s_axis_tready, 1'b0);
        chk("t3_accepted", beats_acc, 3);
        @(posedge clk);
        #1;
`ifdef AXIS_RING_STATS_EN
        chk("t3_stall_grows", stall_count > st0, 1'b1);
`else
        chk("t3_stall_zero", stall_count, 0);
`endif
        cfg_rd_offs = 24'h40;
      end
    join
    wait_drain();
    chk("t3_frames", frame_count, 1);
    chk("t3_wr_offs", wr_offs, 0);

    // Disabled ring drops the whole frame.
    cfg_enable = 1'b0;
    send_frame(5, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_mvalid", m_axis_tvalid, 1'b0);
    chk("t4_wr_offs", wr_offs, 0);
    chk("t4_frames", frame_count, 1);
`ifdef AXIS_RING_STATS_EN
    chk("t4_drops", drop_count, 1);
`else
    chk("t4_drops", drop_count, 0);
`endif

    // Enable falling mid-frame must not truncate.
    cfg_enable = 1'b1;
    cfg_rd_offs = '0;
    beats_acc = 0;
    fork
      send_frame(3, 1'b1, 0);
      begin
        w = 0;
        while (beats_acc < 1 && w < 100) begin
          w++;
          @(negedge clk);
        end
        @(posedge clk);
        #1 cfg_enable = 1'b0;
      end
    join
    wait_drain();
    chk("t5_frames", frame_count, 2);
    chk("t5_wr_offs", wr_offs, 24'hc0);
    cfg_enable = 1'b1;

    // Reset in the middle of a frame.
    cfg_rd_offs = 24'hc0;
    send_frame(4, 1'b1, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_mvalid", m_axis_tvalid, 1'b0);
    chk("t6_maddr", m_addr, 0);
    chk("t6_mdata", m_axis_tdata, 0);
    chk("t6_mlast", m_axis_tlast, 1'b0);
    chk("t6_tready", s_axis_tready, 1'b0);
    chk("t6_wr_offs", wr_offs, 0);
    chk("t6_frames", frame_count, 0);
    do_reset();
    cfg_rd_offs = '0;
    send_frame(1, 1'b1, 0);
    wait_drain();
    chk("t6_next_wr", wr_offs, 24'h40);
    chk("t6_next_frames", frame_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
